axi2mem_wr_cmd_gen: RTL and testbench

AXI write-address burst expander for the axi2mem write path. It accepts one AW transaction at a time and emits one per-beat command (id, byte address, last flag) on the trans req/gnt handshake. The consumer is the TCDM write interface, which pairs each command with one write-data word. FIXED, INCR and WRAP bursts are supported on a 32-bit data bus.

---
 rtl/axi2mem_pkg.sv | 30 +++
 rtl/axi2mem_wr_cmd_gen_if.sv | 41 ++++
 rtl/axi2mem_burst_addr.sv | 36 +++
 rtl/axi2mem_wr_cmd_gen.sv | 117 +++++++++++
 tb/tb_axi2mem_wr_cmd_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi2mem_pkg.sv
// Shared definitions for the axi2mem command generators: burst encodings,
// FSM state type and beat-size helpers for the 32-bit data bus.
package axi2mem_pkg;

    localparam int unsigned AXI_LEN_WIDTH   = 8;
    localparam int unsigned AXI_SIZE_WIDTH  = 3;
    localparam int unsigned AXI_BURST_WIDTH = 2;
    localparam int unsigned AXI_SIZE_MAX    = 2;

    localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_e;

    // Beats wider than the data bus are narrowed to the bus width.
    function automatic logic [AXI_SIZE_WIDTH-1:0] clamp_size(input logic [AXI_SIZE_WIDTH-1:0] size);
        return (size > AXI_SIZE_WIDTH'(AXI_SIZE_MAX)) ? AXI_SIZE_WIDTH'(AXI_SIZE_MAX) : size;
    endfunction

    // Only 2, 4, 8 or 16 beat bursts may wrap.
    function automatic logic wrap_len_ok(input logic [AXI_LEN_WIDTH-1:0] len);
        return (len == AXI_LEN_WIDTH'(1)) || (len == AXI_LEN_WIDTH'(3)) ||
               (len == AXI_LEN_WIDTH'(7)) || (len == AXI_LEN_WIDTH'(15));
    endfunction

endpackage

// File: rtl/axi2mem_wr_cmd_gen_if.sv
// AW channel plus per-beat command handshake of the write command generator.
interface axi2mem_wr_cmd_gen_if #(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) ();
    import axi2mem_pkg::*;

    logic [AXI_ID_WIDTH-1:0]    aw_id_i;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr_i;
    logic [AXI_LEN_WIDTH-1:0]   aw_len_i;
    logic [AXI_SIZE_WIDTH-1:0]  aw_size_i;
    logic [AXI_BURST_WIDTH-1:0] aw_burst_i;
    logic                       aw_valid_i;
    logic                       aw_ready_o;

    logic [AXI_ID_WIDTH-1:0]    trans_id_o;
    logic [AXI_ADDR_WIDTH-1:0]  trans_add_o;
    logic                       trans_last_o;
    logic                       trans_req_o;
    logic                       trans_gnt_i;
    logic                       busy_o;

    // Command generator side.
    modport slave (
        input  aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_valid_i,
        output aw_ready_o,
        output trans_id_o, trans_add_o, trans_last_o, trans_req_o,
        input  trans_gnt_i,
        output busy_o
    );

    // AXI master / TCDM consumer side.
    modport master (
        output aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_valid_i,
        input  aw_ready_o,
        input  trans_id_o, trans_add_o, trans_last_o, trans_req_o,
        output trans_gnt_i,
        input  busy_o
    );

endinterface

// File: rtl/axi2mem_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Shared between the read and write command generators.
module axi2mem_burst_addr
    import axi2mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]      addr_i,
    input  logic [AXI_LEN_WIDTH-1:0]   len_i,
    input  logic [AXI_SIZE_WIDTH-1:0]  size_i,
    input  logic [AXI_BURST_WIDTH-1:0] burst_i,
    output logic [ADDR_WIDTH-1:0]      next_addr_c
);

    logic [AXI_SIZE_WIDTH-1:0] size_cl;
    logic [ADDR_WIDTH-1:0]     step;
    logic [ADDR_WIDTH-1:0]     wrap_mask;
    logic [ADDR_WIDTH-1:0]     incr_addr;
    logic [ADDR_WIDTH-1:0]     wrap_addr;

    // Aligned increment, wrap within the burst window, or hold for FIXED.
    always_comb begin
        size_cl     = clamp_size(size_i);
        step        = ADDR_WIDTH'(1) << size_cl;
        incr_addr   = (addr_i & ~(step - ADDR_WIDTH'(1))) + step;
        wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_cl) - ADDR_WIDTH'(1);
        wrap_addr   = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
        next_addr_c = incr_addr;
        case (burst_i)
            BURST_FIXED: next_addr_c = addr_i;
            BURST_WRAP:  next_addr_c = wrap_len_ok(len_i) ? wrap_addr : incr_addr;
            default:     next_addr_c = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi2mem_wr_cmd_gen.sv
// AXI write-address burst expander: takes one AW transaction at a time and
// issues one registered command (id, byte address, last) per beat on req/gnt.
module axi2mem_wr_cmd_gen
    import axi2mem_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    axi2mem_wr_cmd_gen_if.slave bus
);

    wr_state_e                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]    id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0]  add_q, add_d;
    logic [AXI_LEN_WIDTH-1:0]   len_q, len_d;
    logic [AXI_LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [AXI_SIZE_WIDTH-1:0]  size_q, size_d;
    logic [AXI_BURST_WIDTH-1:0] burst_q, burst_d;
    logic                       req_q, req_d;
    logic                       last_q, last_d;
    logic                       aw_ready_q, aw_ready_d;
    logic                       busy_q, busy_d;
    logic [AXI_ADDR_WIDTH-1:0]  next_add;

    // Address of the beat following the one currently presented.
    axi2mem_burst_addr #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_burst_addr (
        .addr_i      (add_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_c (next_add)
    );

    // Next state: accept AW in IDLE, step one beat per grant in BURST.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        add_d   = add_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // aw_ready_q is low for the first cycle out of reset.
                if (bus.aw_valid_i && aw_ready_q) begin
                    state_d = BURST;
                    id_d    = bus.aw_id_i;
                    add_d   = bus.aw_addr_i;
                    len_d   = bus.aw_len_i;
                    cnt_d   = bus.aw_len_i;
                    size_d  = clamp_size(bus.aw_size_i);
                    burst_d = bus.aw_burst_i;
                    last_d  = (bus.aw_len_i == '0);
                end
            end
            BURST: begin
                if (bus.trans_gnt_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        add_d  = next_add;
                        cnt_d  = cnt_q - AXI_LEN_WIDTH'(1);
                        last_d = (cnt_q == AXI_LEN_WIDTH'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        req_d      = (state_d == BURST);
        busy_d     = (state_d == BURST);
        aw_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops the burst immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            add_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            req_q      <= 1'b0;
            last_q     <= 1'b0;
            aw_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            add_q      <= add_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            req_q      <= req_d;
            last_q     <= last_d;
            aw_ready_q <= aw_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.aw_ready_o   = aw_ready_q;
    assign bus.trans_id_o   = id_q;
    assign bus.trans_add_o  = add_q;
    assign bus.trans_last_o = last_q;
    assign bus.trans_req_o  = req_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_axi2mem_wr_cmd_gen.sv
// Testbench for axi2mem_wr_cmd_gen: directed vector table, hand-written
// stall / reset sequences and randomized bursts against an address model.
module tb_axi2mem_wr_cmd_gen;
    import axi2mem_pkg::*;

    localparam int unsigned IDW = 6;
    localparam int unsigned ADW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_q [$];

    typedef struct packed {
        logic [5:0]        id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [0:3][31:0]  exp_add;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    axi2mem_wr_cmd_gen_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(ADW)) bus ();

    axi2mem_wr_cmd_gen #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_ADDR_WIDTH (ADW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // AXI beat addresses from the absolute-address formulas.
    function automatic void model(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        longint unsigned sz    = (size > 3'd2) ? 2 : longint'(size);
        longint unsigned bytes = longint'(1) << sz;
        longint unsigned n     = longint'(len) + 1;
        longint unsigned total = n * bytes;
        longint unsigned a0    = longint'(addr);
        longint unsigned lower = a0 - (a0 % total);
        bit wrap = (burst == 2'b10) && (n == 2 || n == 4 || n == 8 || n == 16);
        for (longint unsigned i = 0; i < n; i++) begin
            longint unsigned a;
            if (burst == 2'b00)  a = a0;
            else if (wrap)       a = lower + ((a0 - lower + i * bytes) % total);
            else if (i == 0)     a = a0;
            else                 a = (a0 - (a0 % bytes)) + i * bytes;
            exp_q.push_back(32'(a));
        end
    endfunction

    // Idle cycles with stray grants that must be ignored.
    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            bus.trans_gnt_i = 1'($urandom_range(0, 1));
            chk("idle_req", 32'(bus.trans_req_o), 32'd0);
            @(negedge clk);
        end
        bus.trans_gnt_i = 1'b0;
    endtask

    // One AW handshake then one check per cycle until the burst drains.
    task automatic run_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_max, input bit noise);
        logic [31:0] e;
        int stalls;
        chk("aw_ready_pre", 32'(bus.aw_ready_o), 32'd1);
        chk("req_pre", 32'(bus.trans_req_o), 32'd0);
        bus.aw_id_i     = id;
        bus.aw_addr_i   = addr;
        bus.aw_len_i    = len;
        bus.aw_size_i   = size;
        bus.aw_burst_i  = burst;
        bus.aw_valid_i  = 1'b1;
        bus.trans_gnt_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        bus.aw_valid_i = noise;
        if (noise) begin
            bus.aw_id_i   = 6'($urandom);
            bus.aw_addr_i = $urandom;
            bus.aw_len_i  = 8'($urandom);
        end
        for (int i = 0; i <= int'(len); i++) begin
            stalls = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
            e = exp_q.pop_front();
            for (int s = 0; s <= stalls; s++) begin
                chk("req", 32'(bus.trans_req_o), 32'd1);
                chk("add", bus.trans_add_o, e);
                chk("id", 32'(bus.trans_id_o), 32'(id));
                chk("last", 32'(bus.trans_last_o), 32'(i == int'(len)));
                chk("aw_ready_busy", 32'(bus.aw_ready_o), 32'd0);
                chk("busy", 32'(bus.busy_o), 32'd1);
                bus.trans_gnt_i = (s == stalls);
                if (i == int'(len) && s == stalls) bus.aw_valid_i = 1'b0;
                @(negedge clk);
            end
        end
        bus.trans_gnt_i = 1'b0;
        chk("aw_ready_post", 32'(bus.aw_ready_o), 32'd1);
        chk("req_post", 32'(bus.trans_req_o), 32'd0);
        chk("busy_post", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{id: 6'h2A, addr: 32'h1000, len: 8'd3, size: 3'd2, burst: 2'b01,
                    exp_add: {32'h1000, 32'h1004, 32'h1008, 32'h100C}};
        vecs[1] = '{id: 6'h11, addr: 32'h1008, len: 8'd3, size: 3'd2, burst: 2'b10,
                    exp_add: {32'h1008, 32'h100C, 32'h1000, 32'h1004}};
        vecs[2] = '{id: 6'h05, addr: 32'h2000, len: 8'd2, size: 3'd2, burst: 2'b00,
                    exp_add: {32'h2000, 32'h2000, 32'h2000, 32'h0}};
        vecs[3] = '{id: 6'h01, addr: 32'h1003, len: 8'd1, size: 3'd2, burst: 2'b01,
                    exp_add: {32'h1003, 32'h1004, 32'h0, 32'h0}};
        vecs[4] = '{id: 6'h3F, addr: 32'hFFFFFFFC, len: 8'd1, size: 3'd2, burst: 2'b01,
                    exp_add: {32'hFFFFFFFC, 32'h0, 32'h0, 32'h0}};
        vecs[5] = '{id: 6'h07, addr: 32'h5000, len: 8'd0, size: 3'd2, burst: 2'b01,
                    exp_add: {32'h5000, 32'h0, 32'h0, 32'h0}};
        vecs[6] = '{id: 6'h12, addr: 32'h6001, len: 8'd3, size: 3'd5, burst: 2'b11,
                    exp_add: {32'h6001, 32'h6004, 32'h6008, 32'h600C}};
        vecs[7] = '{id: 6'h20, addr: 32'h7006, len: 8'd2, size: 3'd1, burst: 2'b10,
                    exp_add: {32'h7006, 32'h7008, 32'h700A, 32'h0}};
        vecs[8] = '{id: 6'h33, addr: 32'h8002, len: 8'd3, size: 3'd0, burst: 2'b10,
                    exp_add: {32'h8002, 32'h8003, 32'h8000, 32'h8001}};
        vecs[9] = '{id: 6'h0C, addr: 32'h9004, len: 8'd1, size: 3'd2, burst: 2'b10,
                    exp_add: {32'h9004, 32'h9000, 32'h0, 32'h0}};

        rst             = 1'b1;
        bus.aw_id_i     = '0;
        bus.aw_addr_i   = '0;
        bus.aw_len_i    = '0;
        bus.aw_size_i   = '0;
        bus.aw_burst_i  = '0;
        bus.aw_valid_i  = 1'b0;
        bus.trans_gnt_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.trans_req_o), 32'd0);
        chk("rst_last", 32'(bus.trans_last_o), 32'd0);
        chk("rst_id", 32'(bus.trans_id_o), 32'd0);
        chk("rst_add", bus.trans_add_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_aw_ready", 32'(bus.aw_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("aw_ready_after_rst", 32'(bus.aw_ready_o), 32'd1);

        // Directed vectors, grant always high.
        for (int v = 0; v < NVEC; v++) begin
            exp_q.delete();
            for (int j = 0; j <= int'(vecs[v].len); j++) exp_q.push_back(vecs[v].exp_add[j]);
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0, 1'b0);
        end

        // INCR len 7 with random 0-5 cycle grant stalls.
        exp_q.delete();
        for (int j = 0; j < 8; j++) exp_q.push_back(32'h1100 + 32'(4 * j));
        run_burst(6'h19, 32'h1100, 8'd7, 3'd2, 2'b01, 5, 1'b0);

        // Reset in the middle of a len 7 burst.
        bus.aw_id_i    = 6'h15;
        bus.aw_addr_i  = 32'h4000;
        bus.aw_len_i   = 8'd7;
        bus.aw_size_i  = 3'd2;
        bus.aw_burst_i = 2'b01;
        bus.aw_valid_i = 1'b1;
        @(negedge clk);
        bus.aw_valid_i  = 1'b0;
        chk("mid_b0", bus.trans_add_o, 32'h4000);
        bus.trans_gnt_i = 1'b1;
        @(negedge clk);
        chk("mid_b1", bus.trans_add_o, 32'h4004);
        @(negedge clk);
        chk("mid_b2", bus.trans_add_o, 32'h4008);
        chk("mid_b2_req", 32'(bus.trans_req_o), 32'd1);
        bus.trans_gnt_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.trans_req_o), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_aw_ready", 32'(bus.aw_ready_o), 32'd0);
        chk("mid_rst_add", bus.trans_add_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_aw_ready", 32'(bus.aw_ready_o), 32'd1);
        exp_q.delete();
        for (int j = 0; j < 4; j++) exp_q.push_back(32'h3000 + 32'(4 * j));
        run_burst(6'h09, 32'h3000, 8'd3, 3'd2, 2'b01, 0, 1'b0);

        // Randomized bursts against the address model.
        for (int r = 0; r < 60; r++) begin
            logic [5:0]  rid;
            logic [31:0] raddr;
            logic [7:0]  rlen;
            logic [2:0]  rsize;
            logic [1:0]  rburst;
            rid    = 6'($urandom);
            raddr  = $urandom;
            rlen   = 8'($urandom_range(0, 15));
            rsize  = 3'($urandom_range(0, 7));
            rburst = 2'($urandom_range(0, 3));
            exp_q.delete();
            model(raddr, rlen, rsize, rburst);
            run_burst(rid, raddr, rlen, rsize, rburst, $urandom_range(0, 3), 1'b1);
            idle_gap($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
